// File: rtl/add32_seq2pass.sv
// add32_seq2pass: two-pass 32-bit add/subtract through one shared 16-bit adder.
// Optional ADD32_CARRY_IN_EN adds cin_ext as the low-pass carry-in (ADC/SBC).
module add32_seq2pass_cla16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);
    logic [15:0] g, p, c;
    logic [3:0]  gg, pg;
    logic [4:0]  cg;
    assign g = x & y;
    assign p = x ^ y;
    // 4-bit groups: group carries by lookahead, bits within a group ripple
    always_comb begin
        gg = '0;
        pg = '0;
        cg = '0;
        c  = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            pg[j] = &p[4*j +: 4];
        end
        cg[0] = ci;
        for (int j = 0; j < 4; j++) cg[j+1] = gg[j] | (pg[j] & cg[j]);
        c[0] = cg[0];
        for (int i = 0; i < 15; i++) c[i+1] = ((i + 1) % 4 == 0) ? cg[(i+1)/4] : (g[i] | (p[i] & c[i]));
    end
    assign s  = p ^ c;
    assign co = cg[4];
endmodule

module add32_seq2pass (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef ADD32_CARRY_IN_EN
    input  logic        cin_ext,
`endif
    output logic        busy,
    output logic        valid,
    output logic [31:0] result,
    output logic        flag_c,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_v
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;
    state_t state, next_state;
    logic [31:0] op_a, op_b;
    logic [15:0] s_lo, ax, bx, s;
    logic        cin0, c_mid, ci, co, cin_sel, hi;
`ifdef ADD32_CARRY_IN_EN
    assign cin_sel = cin_ext;
`else
    assign cin_sel = sub;
`endif
    assign hi   = (state == HI);
    assign ax   = hi ? op_a[31:16] : op_a[15:0];
    assign bx   = hi ? op_b[31:16] : op_b[15:0];
    assign ci   = hi ? c_mid : cin0;
    assign busy = (state != IDLE);
    add32_seq2pass_cla16 u_add (.x(ax), .y(bx), .ci(ci), .s(s), .co(co));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? LO : IDLE;
            LO:      next_state = HI;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            cin0   <= 1'b0;
            s_lo   <= '0;
            c_mid  <= 1'b0;
            valid  <= 1'b0;
            result <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE && start) begin
                op_a <= a;
                op_b <= b ^ {32{sub}};
                cin0 <= cin_sel;
            end
            if (state == LO) begin
                s_lo  <= s;
                c_mid <= co;
            end
            if (hi) begin
                result <= {s, s_lo};
                flag_c <= co;
                flag_z <= ~|{s, s_lo};
                flag_n <= s[15];
                flag_v <= (op_a[31] == op_b[31]) && (s[15] != op_a[31]);
                valid  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_add32_seq2pass.sv
// tb_add32_seq2pass: directed table, corner sequences and random ops against an arithmetic model.
module tb_add32_seq2pass;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0, cin_ext = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic busy, valid, flag_c, flag_z, flag_n, flag_v;
    logic [31:0] result;
    int checks = 0, errors = 0, vcount = 0;

    add32_seq2pass dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
`ifdef ADD32_CARRY_IN_EN
        .cin_ext(cin_ext),
`endif
        .busy(busy), .valid(valid), .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (valid === 1'b1) vcount++;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {logic [31:0] r; logic c, z, n, v;} res_t;
    typedef struct {logic [31:0] x, y; logic s; res_t e;} vec_t;

    function automatic res_t model(input logic [31:0] x, y, input logic s, ci);
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint u, sg;
        res_t m;
        u  = s ? ux - uy - (ci ? 0 : 1) : ux + uy + (ci ? 1 : 0);
        sg = s ? sx - sy - (ci ? 0 : 1) : sx + sy + (ci ? 1 : 0);
        m.r = u[31:0];
        m.c = s ? (u >= 0) : (u >= 64'h1_0000_0000);
        m.v = (sg > 64'sh7FFF_FFFF) || (sg < -64'sh8000_0000);
        m.z = (m.r == 0);
        m.n = m.r[31];
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, " result"}, result, e.r);
        chk({tag, " flags_cznv"}, {28'b0, flag_c, flag_z, flag_n, flag_v}, {28'b0, e.c, e.z, e.n, e.v});
    endtask

    // drive one request, scramble inputs after acceptance, return negedges until valid
    task automatic run_op(input logic [31:0] x, y, input logic s, ci, output int lat);
        @(negedge clk);
        a = x; b = y; sub = s; cin_ext = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; sub = ~s; cin_ext = ~ci;
        lat = 1;
        while (valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t tab[6];
    int lat, v0;
    logic [31:0] x, y;
    logic s, ci;
    res_t e;

    initial begin
        tab[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, '{32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0}};
        tab[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}};
        tab[2] = '{32'h80000000, 32'h00000001, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1}};
        tab[3] = '{32'h00000003, 32'h00000005, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0}};
        tab[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, '{32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1}};
        tab[5] = '{32'h00000005, 32'h00000005, 1'b1, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}};

        repeat (3) @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset valid", {31'b0, valid}, 32'd0);
        chk_res("reset", '{32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        foreach (tab[i]) begin
            run_op(tab[i].x, tab[i].y, tab[i].s, tab[i].s, lat);
            chk($sformatf("vec%0d latency", i), lat, 3);
            chk_res($sformatf("vec%0d", i), tab[i].e);
            @(negedge clk);
            chk($sformatf("vec%0d valid one cycle", i), {31'b0, valid}, 32'd0);
        end

        // reset in LO aborts the op and clears the outputs
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; sub = 1'b0; cin_ext = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort busy before rst", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort busy", {31'b0, busy}, 32'd0);
        v0 = vcount;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort no valid", vcount - v0, 0);
        chk_res("abort", '{32'h0, 1'b0, 1'b0, 1'b0, 1'b0});

        // start while busy is ignored
        v0 = vcount;
        @(negedge clk);
        a = 32'h00000003; b = 32'h00000005; sub = 1'b1; cin_ext = 1'b1; start = 1'b1;
        @(negedge clk);
        a = 32'hAAAA0000; b = 32'h5555FFFF; sub = 1'b0; cin_ext = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        chk("ignore valid", {31'b0, valid}, 32'd1);
        chk_res("ignore", '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0});
        repeat (5) @(negedge clk);
        chk("ignore single valid", vcount - v0, 1);
        chk("ignore idle", {31'b0, busy}, 32'd0);
        chk_res("ignore hold", '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0});

        // start held in the valid cycle is accepted; valids 3 cycles apart
        run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, lat);
        chk("b2b first latency", lat, 3);
        a = 32'h00000010; b = 32'h00000020; sub = 1'b1; cin_ext = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b spacing", lat, 3);
        chk_res("b2b second", '{32'hFFFFFFF0, 1'b0, 1'b0, 1'b1, 1'b0});

`ifdef ADD32_CARRY_IN_EN
        run_op(32'h5, 32'h2, 1'b1, 1'b0, lat);
        chk("sbc cin0 result", result, 32'h2);
        chk("sbc cin0 c", {31'b0, flag_c}, 32'd1);
        run_op(32'h5, 32'h2, 1'b1, 1'b1, lat);
        chk("sbc cin1 result", result, 32'h3);
`endif

        for (int k = 0; k < 40; k++) begin
            x = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
            y = ($urandom_range(0, 3) == 0) ? ~32'($urandom_range(0, 1)) : $urandom;
            s = 1'($urandom_range(0, 1));
`ifdef ADD32_CARRY_IN_EN
            ci = 1'($urandom_range(0, 1));
`else
            ci = s;
`endif
            e = model(x, y, s, ci);
            run_op(x, y, s, ci, lat);
            chk($sformatf("rand%0d latency", k), lat, 3);
            chk_res($sformatf("rand%0d", k), e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/add32_seq2pass.md
Name: add32_seq2pass

Overview:
- Multi-cycle 32-bit add/subtract unit for the miniRISC ALU path.
- Drives one instance of the team's existing 16-bit lookahead-carry adder twice per operation: low half first, then high half with the registered carry.
- Upstream it takes operands and a start strobe from the ALU control. Downstream it delivers a registered 32-bit result and C/Z/N/V flags to the writeback and flag registers.
- Trades one extra cycle for half the adder area.

Parameters:
- none. Width is fixed at 32, built from two 16-bit passes.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- sub  in  1  0 = a+b, 1 = a-b; sampled with start
- a  in  32  operand A; sampled with start
- b  in  32  operand B; sampled with start
- busy  out  1  high while an operation is in flight (state != IDLE)
- valid  out  1  one-cycle pulse: result and flags updated
- result  out  32  registered sum/difference
- flag_c  out  1  carry out of bit 31 (subtract: 1 = no borrow)
- flag_z  out  1  result == 0
- flag_n  out  1  result[31]
- flag_v  out  1  signed overflow

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, valid=0, result=0, all flags=0, internal operand/carry registers=0.
  - Reset mid-operation aborts it with no valid pulse.
- Operand latching:
  - On the edge sampling start=1 in IDLE: latch opA=a, opB = b XOR {32{sub}}, cin0 = sub.
  - Then go to LO.
- State LO:
  - Adder inputs are opA[15:0], opB[15:0], cin0.
  - At the next edge, register s_lo and c_mid (adder cout), then go to HI.
- State HI:
  - Adder inputs are opA[31:16], opB[31:16], c_mid.
  - At the next edge:
    - result = {s, s_lo}
    - flag_c = cout
    - flag_z = (result == 0)
    - flag_n = s[15]
    - flag_v = (opA[31] == opB[31]) && (s[15] != opA[31])
    - valid = 1; go to IDLE.
- valid is high for exactly one cycle; it is 0 in every other cycle.
- Latency and throughput:
  - Start accepted at edge k; valid is high in the cycle after edge k+2.
  - A start asserted during the valid cycle is accepted, so throughput is one op per 3 cycles.
- start while busy=1 is ignored; it is not queued and its operands are not latched.
- a, b and sub may change freely after acceptance.
- Outputs:
  - result and flags hold their values until the next completed operation.
  - Aborted and ignored requests never modify them.
- Wrap-around: arithmetic is modulo 2^32. The carry beyond bit 31 appears only on flag_c.
- Adder block P/G outputs are unused.

Optional Feature:
- Macro: ADD32_CARRY_IN_EN
- Defined:
  - Adds input port cin_ext (1 bit), sampled with start.
  - cin0 = cin_ext regardless of sub, giving ADC/SBC with carry-as-not-borrow semantics. Example: a-b with cin_ext=0 yields a-b-1.
- Undefined:
  - No cin_ext port; cin0 = sub.

Test Plan:
- Reset then idle: rst pulse mid-LO after a start → busy=0, valid never asserts, result=0, all flags 0.
- Add across half boundary: a=0x0000FFFF, b=0x00000001, sub=0 → valid 2 edges after acceptance; result=0x00010000, C=0, Z=0, N=0, V=0.
- Full carry wrap: a=0xFFFFFFFF, b=0x00000001, sub=0 → result=0x00000000, C=1, Z=1, N=0, V=0.
- Signed overflow on subtract: a=0x80000000, b=0x00000001, sub=1 → result=0x7FFFFFFF, C=1, V=1, N=0, Z=0.
- Borrow: a=0x00000003, b=0x00000005, sub=1 → result=0xFFFFFFFE, C=0, N=1, V=0. In the same run:
  - start pulsed while busy → ignored, with a single valid pulse.
  - start held during the valid cycle → next op accepted, with valids exactly 3 cycles apart.
- With ADD32_CARRY_IN_EN:
  - a=0x00000005, b=0x00000002, sub=1, cin_ext=0 → result=0x00000002, C=1.
  - Same operands with cin_ext=1 → 0x00000003.
